mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequencer between the CPU datapath and the byte-addressed 256x8 RAM.
- Accepts one load/store request per MFA pulse: byte, halfword, word or doubleword. Drives the RAM's level-sensitive Enable/ReadWrite/Mode/Address/DataIn strobes with setup and hold margins.
- Splits each doubleword into two word beats, merges and extends read data, and signals completion on MFC.
- Only block allowed to drive the RAM strobes.

Parameters:
- STROBE_CYCLES, 2, clock cycles RamEnable is held high per beat (legal range 1..15).
- ADDR_W, 8, RAM byte-address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- MFA  input  1  memory function asserted; request accepted when high in IDLE.
- ReadWrite  input  1  1 = load, 0 = store (same polarity as the RAM).
- Mode  input  2  00 byte, 01 halfword, 10 word, 11 doubleword.
- Signed  input  1  loads only: 1 = sign-extend byte/halfword, 0 = zero-extend.
- Address  input  ADDR_W  byte address of the first byte (MSB-first ordering).
- WrData  input  64  store data, right-aligned; doubleword uses all 64 bits.
- RdData  output  64  load result.
- MFC  output  1  one-cycle completion pulse.
- Busy  output  1  high from acceptance until the cycle after MFC.
- AlignErr  output  1  misaligned-request flag, pulses with MFC.
- RamEnable  output  1  RAM Enable.
- RamReadWrite  output  1  RAM ReadWrite.
- RamMode  output  2  RAM Mode; never driven to 11.
- RamAddress  output  ADDR_W  RAM Address.
- RamDataIn  output  32  RAM DataIn.
- RamDataOut  input  32  RAM DataOut.

Behaviour:
Reset state (asynchronous on Reset high):
- State is IDLE.
- All outputs are 0: RdData, MFC, Busy, AlignErr, RamEnable, RamReadWrite, RamMode, RamAddress, RamDataIn.
- Reset high mid-access drops RamEnable immediately. The partial access is abandoned and no MFC is issued.

Request acceptance:
- MFA is sampled only in IDLE. ReadWrite, Mode, Signed, Address and WrData are latched on the acceptance edge and may change afterwards.
- MFA is ignored while Busy. There is no queueing.

States:
- IDLE: acceptance moves to SETUP, Busy goes to 1, and the beat counter is cleared.
- SETUP (1 cycle): RamAddress, RamMode, RamReadWrite and RamDataIn are driven; RamEnable = 0.
- STROBE (STROBE_CYCLES cycles): RamEnable = 1. On a load, RamDataOut is captured at the last STROBE edge.
- HOLD (1 cycle): RamEnable = 0; address, mode and data unchanged.
  - If a doubleword and beat 0: go to SETUP with beat 1.
  - Otherwise: go to DONE.
- DONE (1 cycle): MFC = 1; RdData updated on the same edge MFC rises; next state IDLE, Busy falls.

Latency:
- MFC is high exactly STROBE_CYCLES+3 cycles after the acceptance edge.
- Doubleword latency is 2*(STROBE_CYCLES+2)+1 cycles.

Beat mapping:
- Byte, halfword, word: one beat; RamMode = Mode; RamAddress = Address.
- Doubleword: beat 0 is a word (RamMode = 10) at Address; beat 1 is a word at Address+4, wrapping modulo 256.

Store data (RamDataIn):
- Byte: {24'b0, WrData[7:0]}.
- Halfword: {16'b0, WrData[15:0]}.
- Word: WrData[31:0].
- Doubleword: beat 0 = WrData[63:32], beat 1 = WrData[31:0].

Load data (RdData):
- Byte: RamDataOut[7:0], extended to 64 bits per Signed.
- Halfword: RamDataOut[15:0], extended to 64 bits per Signed.
- Word: {32'b0, RamDataOut}; Signed is ignored.
- Doubleword: {beat0, beat1}.
- Stores leave RdData unchanged.

Address wrap: a multi-byte beat crossing 0xFF wraps inside the RAM. The controller adds no checking beyond the optional feature.

Optional Feature:
Macro ALIGN_CHECK_EN.
- Defined:
  - A request is misaligned when:
    - Halfword: Address[0] != 0.
    - Word: Address[1:0] != 0.
    - Doubleword: Address[2:0] != 0.
  - A misaligned request goes from IDLE straight to DONE. There is no RAM activity: RamEnable stays 0 and the Ram* outputs are unchanged.
  - MFC and AlignErr pulse together one cycle after acceptance; RdData is unchanged.
- Undefined: AlignErr is tied to 0, and every request executes as given with modulo-256 wrap.

Test Plan:
- Reset, then store word 0xDEADBEEF at 0x10, then load word at 0x10. Required: RdData = 0x00000000DEADBEEF, MFC at acceptance+5 cycles (STROBE_CYCLES=2), RamEnable high exactly 2 cycles per beat.
- Store byte 0x80 at 0x21, then load byte with Signed=1 and Signed=0. Required: RdData = 0xFFFFFFFFFFFFFF80 and 0x0000000000000080.
- Store doubleword 0x0123456789ABCDEF at 0xFC. Required: beat 1 RamAddress = 0x00. Loading doubleword at 0xFC returns 0x0123456789ABCDEF, MFC after 9 cycles.
- Pulse MFA repeatedly during a word load. Required: exactly one access and one MFC; Busy high throughout.
- Assert Reset in the second STROBE cycle of a store. Required: RamEnable low within the same cycle, no MFC; the next request completes normally.
- With ALIGN_CHECK_EN, load word at 0x02. Required: MFC and AlignErr high at acceptance+1, RamEnable never high. Without the macro, the same load executes normally with AlignErr = 0.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// CPU-side request/response bus of the RAM access sequencer.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 8
);
    // MFA is the request valid. The controller is ready only while Busy is low.
    // A request is taken on the first rising edge with MFA high and Busy low.
    // ReadWrite, Mode, Signed, Address and WrData are sampled only on that edge.
    // MFC is a one-cycle done pulse. RdData and AlignErr are valid while MFC is high.
    logic              MFA;
    logic              ReadWrite;
    logic [1:0]        Mode;
    logic              Signed;
    logic [ADDR_W-1:0] Address;
    logic [63:0]       WrData;
    logic [63:0]       RdData;
    logic              MFC;
    logic              Busy;
    logic              AlignErr;

    modport master (
        output MFA, ReadWrite, Mode, Signed, Address, WrData,
        input  RdData, MFC, Busy, AlignErr
    );

    modport slave (
        input  MFA, ReadWrite, Mode, Signed, Address, WrData,
        output RdData, MFC, Busy, AlignErr
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer driving the level-sensitive 256x8 RAM strobes; splits doublewords into two word beats.
// Optional misalignment trap enabled by defining ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int STROBE_CYCLES = 2,
    parameter int ADDR_W        = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    mem_access_ctrl_if.slave    cpu,
    output logic                RamEnable,
    output logic                RamReadWrite,
    output logic [1:0]          RamMode,
    output logic [ADDR_W-1:0]   RamAddress,
    output logic [31:0]         RamDataIn,
    input  logic [31:0]         RamDataOut,
    output logic [2:0]          o_dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_STROBE = 4'(STROBE_CYCLES - 1);

    state_t            r_state;
    logic              r_beat;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic [1:0]        r_mode;
    logic              r_signed;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata_lo;
    logic [31:0]       r_rd0;
    logic [31:0]       r_rd1;
    logic [63:0]       r_rd_data;
    logic              r_mfc;
    logic              r_busy;
    logic              r_align_err;
    logic              r_ram_en;
    logic              r_ram_rw;
    logic [1:0]        r_ram_mode;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [31:0]       r_ram_din;

    logic              w_misaligned;
    logic [31:0]       w_din_first;
    logic [1:0]        w_beat_mode;

    always_comb begin
        w_misaligned = 1'b0;
`ifdef ALIGN_CHECK_EN
        case (cpu.Mode)
            2'b01:   w_misaligned = cpu.Address[0];
            2'b10:   w_misaligned = |cpu.Address[1:0];
            2'b11:   w_misaligned = |cpu.Address[2:0];
            default: w_misaligned = 1'b0;
        endcase
`else
        w_misaligned = 1'b0;
`endif
    end

    // First beat of a doubleword carries the upper word (MSB-first memory order).
    always_comb begin
        w_din_first = 32'd0;
        w_beat_mode = cpu.Mode;
        case (cpu.Mode)
            2'b00:   w_din_first = {24'd0, cpu.WrData[7:0]};
            2'b01:   w_din_first = {16'd0, cpu.WrData[15:0]};
            2'b10:   w_din_first = cpu.WrData[31:0];
            default: begin
                w_din_first = cpu.WrData[63:32];
                w_beat_mode = 2'b10;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_beat      <= 1'b0;
            r_cnt       <= 4'd0;
            r_rw        <= 1'b0;
            r_mode      <= 2'b00;
            r_signed    <= 1'b0;
            r_addr      <= '0;
            r_wdata_lo  <= 32'd0;
            r_rd0       <= 32'd0;
            r_rd1       <= 32'd0;
            r_rd_data   <= 64'd0;
            r_mfc       <= 1'b0;
            r_busy      <= 1'b0;
            r_align_err <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_rw    <= 1'b0;
            r_ram_mode  <= 2'b00;
            r_ram_addr  <= '0;
            r_ram_din   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cpu.MFA) begin
                        r_rw       <= cpu.ReadWrite;
                        r_mode     <= cpu.Mode;
                        r_signed   <= cpu.Signed;
                        r_addr     <= cpu.Address;
                        r_wdata_lo <= cpu.WrData[31:0];
                        r_busy     <= 1'b1;
                        r_beat     <= 1'b0;
                        r_cnt      <= 4'd0;
                        if (w_misaligned) begin
                            r_state     <= S_DONE;
                            r_mfc       <= 1'b1;
                            r_align_err <= 1'b1;
                        end else begin
                            r_state    <= S_SETUP;
                            r_ram_addr <= cpu.Address;
                            r_ram_mode <= w_beat_mode;
                            r_ram_rw   <= cpu.ReadWrite;
                            r_ram_din  <= w_din_first;
                        end
                    end
                end
                S_SETUP: begin
                    r_ram_en <= 1'b1;
                    r_cnt    <= 4'd0;
                    r_state  <= S_STROBE;
                end
                S_STROBE: begin
                    if (r_cnt == LAST_STROBE) begin
                        r_ram_en <= 1'b0;
                        r_state  <= S_HOLD;
                        if (r_rw) begin
                            if (r_beat) r_rd1 <= RamDataOut;
                            else        r_rd0 <= RamDataOut;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (r_mode == 2'b11 && !r_beat) begin
                        r_beat     <= 1'b1;
                        r_ram_addr <= r_addr + ADDR_W'(4);
                        r_ram_din  <= r_wdata_lo;
                        r_state    <= S_SETUP;
                    end else begin
                        r_state <= S_DONE;
                        r_mfc   <= 1'b1;
                        if (r_rw) begin
                            case (r_mode)
                                2'b00: r_rd_data <= r_signed ? {{56{r_rd0[7]}}, r_rd0[7:0]}
                                                             : {56'd0, r_rd0[7:0]};
                                2'b01: r_rd_data <= r_signed ? {{48{r_rd0[15]}}, r_rd0[15:0]}
                                                             : {48'd0, r_rd0[15:0]};
                                2'b10: r_rd_data <= {32'd0, r_rd0};
                                default: r_rd_data <= {r_rd0, r_rd1};
                            endcase
                        end
                    end
                end
                S_DONE: begin
                    r_mfc       <= 1'b0;
                    r_align_err <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu.RdData   = r_rd_data;
    assign cpu.MFC      = r_mfc;
    assign cpu.Busy     = r_busy;
    assign cpu.AlignErr = r_align_err;
    assign RamEnable    = r_ram_en;
    assign RamReadWrite = r_ram_rw;
    assign RamMode      = r_ram_mode;
    assign RamAddress   = r_ram_addr;
    assign RamDataIn    = r_ram_din;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural MSB-first 256x8 RAM.
module tb_mem_access_ctrl;
  logic        clk;
  logic        rst;
  logic        ram_en;
  logic        ram_rw;
  logic [1:0]  ram_mode;
  logic [7:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [2:0]  dbg_state;

  mem_access_ctrl_if #(.ADDR_W(8)) cpu_if ();

  mem_access_ctrl #(.STROBE_CYCLES(2), .ADDR_W(8)) dut (
    .Clk          (clk),
    .Reset        (rst),
    .cpu          (cpu_if),
    .RamEnable    (ram_en),
    .RamReadWrite (ram_rw),
    .RamMode      (ram_mode),
    .RamAddress   (ram_addr),
    .RamDataIn    (ram_din),
    .RamDataOut   (ram_dout),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [7:0] mem [256] = '{default: 8'h00};

  always @(posedge clk) begin
    if (ram_en && !ram_rw) begin
      case (ram_mode)
        2'b00: mem[ram_addr] <= ram_din[7:0];
        2'b01: begin
          mem[ram_addr]         <= ram_din[15:8];
          mem[8'(ram_addr + 1)] <= ram_din[7:0];
        end
        default: begin
          mem[ram_addr]         <= ram_din[31:24];
          mem[8'(ram_addr + 1)] <= ram_din[23:16];
          mem[8'(ram_addr + 2)] <= ram_din[15:8];
          mem[8'(ram_addr + 3)] <= ram_din[7:0];
        end
      endcase
    end
  end

  always_comb begin
    ram_dout = 32'd0;
    if (ram_en && ram_rw) begin
      case (ram_mode)
        2'b00: ram_dout = {24'd0, mem[ram_addr]};
        2'b01: ram_dout = {16'd0, mem[ram_addr], mem[8'(ram_addr + 1)]};
        default: ram_dout = {mem[ram_addr], mem[8'(ram_addr + 1)],
                             mem[8'(ram_addr + 2)], mem[8'(ram_addr + 3)]};
      endcase
    end
  end

  // bus monitors
  int         en_cycles = 0;
  int         mfc_count = 0;
  int         bad_mode  = 0;
  logic       prev_en   = 1'b0;
  logic [7:0] beat_addr_q[$];

  always @(posedge clk) begin
    if (ram_en) en_cycles <= en_cycles + 1;
    if (cpu_if.MFC) mfc_count <= mfc_count + 1;
    if (ram_en && ram_mode == 2'b11) bad_mode <= bad_mode + 1;
    if (ram_en && !prev_en) beat_addr_q.push_back(ram_addr);
    prev_en <= ram_en;
  end

  // scoreboard
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // driver: issue one request from a negedge, report cycles until MFC
  task automatic do_access(input logic rw, input logic [1:0] mode, input logic sgn,
                           input logic [7:0] addr, input logic [63:0] wd,
                           output int lat, output logic aerr,
                           output logic busy_m, output logic busy_after);
    lat    = -1;
    aerr   = 1'bx;
    busy_m = 1'bx;
    cpu_if.MFA       = 1'b1;
    cpu_if.ReadWrite = rw;
    cpu_if.Mode      = mode;
    cpu_if.Signed    = sgn;
    cpu_if.Address   = addr;
    cpu_if.WrData    = wd;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      cpu_if.MFA     = 1'b0;
      cpu_if.Address = 8'h5A;
      cpu_if.WrData  = 64'hBAD0_BAD0_BAD0_BAD0;
      if (cpu_if.MFC) begin
        lat    = k;
        aerr   = cpu_if.AlignErr;
        busy_m = cpu_if.Busy;
        break;
      end
    end
    @(negedge clk);
    busy_after = cpu_if.Busy;
  endtask

  int         lat;
  logic       aerr, bm, ba;
  int         e0, m0;
  logic       busy_ok;
  logic [7:0] qa0, qa1;

  initial begin
    rst = 1'b1;
    cpu_if.MFA = 1'b0; cpu_if.ReadWrite = 1'b0; cpu_if.Mode = 2'b00;
    cpu_if.Signed = 1'b0; cpu_if.Address = 8'h00; cpu_if.WrData = 64'd0;
    repeat (3) @(negedge clk);
    check("rst_rddata", cpu_if.RdData, 64'd0);
    check("rst_flags", {61'd0, cpu_if.MFC, cpu_if.Busy, cpu_if.AlignErr}, 64'd0);
    check("rst_ram", {21'd0, ram_en, ram_rw, ram_mode, ram_addr, ram_din}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // store word, load word
    e0 = en_cycles;
    do_access(1'b0, 2'b10, 1'b0, 8'h10, 64'hFFFF_0000_DEAD_BEEF, lat, aerr, bm, ba);
    check("sw_latency", 64'(lat), 64'd5);
    check("sw_en_cycles", 64'(en_cycles - e0), 64'd2);
    check("sw_mem", {32'd0, mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 64'hDEAD_BEEF);
    check("sw_busy", {62'd0, bm, ba}, 64'b10);
    check("sw_rddata_kept", cpu_if.RdData, 64'd0);
    e0 = en_cycles;
    do_access(1'b1, 2'b10, 1'b1, 8'h10, 64'd0, lat, aerr, bm, ba);
    check("lw_latency", 64'(lat), 64'd5);
    check("lw_en_cycles", 64'(en_cycles - e0), 64'd2);
    check("lw_rddata", cpu_if.RdData, 64'h0000_0000_DEAD_BEEF);
    check("lw_alignerr", {63'd0, aerr}, 64'd0);

    // byte store, signed and unsigned loads
    do_access(1'b0, 2'b00, 1'b0, 8'h21, 64'h1234_5678_9ABC_DE80, lat, aerr, bm, ba);
    check("sb_mem", {48'd0, mem[8'h21], mem[8'h22]}, 64'h8000);
    do_access(1'b1, 2'b00, 1'b1, 8'h21, 64'd0, lat, aerr, bm, ba);
    check("lb_signed", cpu_if.RdData, 64'hFFFF_FFFF_FFFF_FF80);
    do_access(1'b1, 2'b00, 1'b0, 8'h21, 64'd0, lat, aerr, bm, ba);
    check("lb_unsigned", cpu_if.RdData, 64'h0000_0000_0000_0080);

    // halfword store and signed load
    do_access(1'b0, 2'b01, 1'b0, 8'h30, 64'hFFFF_0000_1234_A55A, lat, aerr, bm, ba);
    check("sh_mem", {32'd0, mem[8'h2F], mem[8'h30], mem[8'h31], mem[8'h32]}, 64'h00A5_5A00);
    do_access(1'b1, 2'b01, 1'b1, 8'h30, 64'd0, lat, aerr, bm, ba);
    check("lh_signed", cpu_if.RdData, 64'hFFFF_FFFF_FFFF_A55A);

    // doubleword store wrapping past 0xFF
    beat_addr_q.delete();
    e0 = en_cycles;
    do_access(1'b0, 2'b11, 1'b0, 8'hFC, 64'h0123_4567_89AB_CDEF, lat, aerr, bm, ba);
    check("sd_latency", 64'(lat), 64'd9);
    check("sd_en_cycles", 64'(en_cycles - e0), 64'd4);
    check("sd_beats", 64'(beat_addr_q.size()), 64'd2);
    qa0 = (beat_addr_q.size() > 0) ? beat_addr_q[0] : 8'hxx;
    qa1 = (beat_addr_q.size() > 1) ? beat_addr_q[1] : 8'hxx;
    check("sd_beat_addrs", {48'd0, qa0, qa1}, 64'hFC00);
    check("sd_mem_hi", {32'd0, mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]}, 64'h0123_4567);
    check("sd_mem_lo", {32'd0, mem[8'h00], mem[8'h01], mem[8'h02], mem[8'h03]}, 64'h89AB_CDEF);
    check("sd_rddata_kept", cpu_if.RdData, 64'hFFFF_FFFF_FFFF_A55A);
    do_access(1'b1, 2'b11, 1'b0, 8'hFC, 64'd0, lat, aerr, bm, ba);
    check("ld_latency", 64'(lat), 64'd9);
    check("ld_rddata", cpu_if.RdData, 64'h0123_4567_89AB_CDEF);

    // MFA pulsed repeatedly during a word load
    m0 = mfc_count;
    e0 = en_cycles;
    busy_ok = 1'b1;
    cpu_if.MFA = 1'b1; cpu_if.ReadWrite = 1'b1; cpu_if.Mode = 2'b10;
    cpu_if.Signed = 1'b0; cpu_if.Address = 8'h10;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (!cpu_if.Busy) busy_ok = 1'b0;
      cpu_if.MFA     = (k < 5) ? ~cpu_if.MFA : 1'b0;
      cpu_if.Address = 8'hFC;
      cpu_if.Mode    = 2'b11;
    end
    repeat (8) @(negedge clk);
    check("mfa_busy_held", {63'd0, busy_ok}, 64'd1);
    check("mfa_one_mfc", 64'(mfc_count - m0), 64'd1);
    check("mfa_one_access", 64'(en_cycles - e0), 64'd2);
    check("mfa_rddata", cpu_if.RdData, 64'h0000_0000_DEAD_BEEF);

    // reset during the second strobe cycle of a store
    m0 = mfc_count;
    cpu_if.MFA = 1'b1; cpu_if.ReadWrite = 1'b0; cpu_if.Mode = 2'b10;
    cpu_if.Address = 8'h40; cpu_if.WrData = 64'h1122_3344;
    @(posedge clk);
    @(negedge clk);
    cpu_if.MFA = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_en_before", {63'd0, ram_en}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_en_drop", {63'd0, ram_en}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_mid_no_mfc", 64'(mfc_count - m0), 64'd0);
    check("rst_mid_idle", {63'd0, cpu_if.Busy}, 64'd0);
    do_access(1'b1, 2'b10, 1'b0, 8'h10, 64'd0, lat, aerr, bm, ba);
    check("post_rst_latency", 64'(lat), 64'd5);
    check("post_rst_rddata", cpu_if.RdData, 64'h0000_0000_DEAD_BEEF);

    // misaligned word load at 0x02
    e0 = en_cycles;
    do_access(1'b1, 2'b10, 1'b0, 8'h02, 64'd0, lat, aerr, bm, ba);
`ifdef ALIGN_CHECK_EN
    check("mis_latency", 64'(lat), 64'd1);
    check("mis_alignerr", {63'd0, aerr}, 64'd1);
    check("mis_no_ram", 64'(en_cycles - e0), 64'd0);
    check("mis_rddata_kept", cpu_if.RdData, 64'h0000_0000_DEAD_BEEF);
`else
    check("mis_latency", 64'(lat), 64'd5);
    check("mis_alignerr", {63'd0, aerr}, 64'd0);
    check("mis_en_cycles", 64'(en_cycles - e0), 64'd2);
    check("mis_rddata", cpu_if.RdData, 64'h0000_0000_CDEF_0000);
`endif
    check("mis_alignerr_clears", {63'd0, cpu_if.AlignErr}, 64'd0);
    check("ram_mode_never_11", 64'(bad_mode), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
